// File: rtl/lab_pkg.sv
// Shared types and constants for the 160x120 VGA drawing lab.
// Holds the draw sequencer state encoding, screen size and the default clear colour.
package lab_pkg;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CLR_RUN = 3'd1,
    S_CLR_REL = 3'd2,
    S_SHP_RUN = 3'd3,
    S_SHP_REL = 3'd4,
    S_DONE    = 3'd5
  } draw_seq_state;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [2:0] BLACK = 3'b000;

endpackage

// File: rtl/draw_sequencer_pixel_mux.sv
// pixel_mux: routes the active engine's pixel onto the VGA adapter.
// Selects clear or shape engine x/y/plot/colour; when neither engine is
// selected, every output is zero. Build macro DRAW_SEQ_CLIP_EN enables
// suppression of plots that fall outside the visible screen.
module pixel_mux
  import lab_pkg::*;
#(
  parameter int SCREEN_W = lab_pkg::SCREEN_W,
  parameter int SCREEN_H = lab_pkg::SCREEN_H
) (
  input  logic       sel_clr,
  input  logic       sel_shp,
  input  logic [2:0] clr_colour,
  input  logic [7:0] clr_x,
  input  logic [6:0] clr_y,
  input  logic       clr_plot,
  input  logic [2:0] shp_colour,
  input  logic [7:0] shp_x,
  input  logic [6:0] shp_y,
  input  logic       shp_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

`ifdef DRAW_SEQ_CLIP_EN
  localparam bit CLIP_ON = 1'b1;
`else
  localparam bit CLIP_ON = 1'b0;
`endif

  localparam logic [7:0] X_LIM = 8'(SCREEN_W);
  localparam logic [6:0] Y_LIM = 7'(SCREEN_H);

  logic       mux_plot;
  logic       in_bounds;

  // Pick the active engine's pixel; the clear engine wins if both selects were ever high.
  always_comb begin
    vga_x      = 8'd0;
    vga_y      = 7'd0;
    vga_colour = BLACK;
    mux_plot   = 1'b0;
    if (sel_clr) begin
      vga_x      = clr_x;
      vga_y      = clr_y;
      vga_colour = clr_colour;
      mux_plot   = clr_plot;
    end else if (sel_shp) begin
      vga_x      = shp_x;
      vga_y      = shp_y;
      vga_colour = shp_colour;
      mux_plot   = shp_plot;
    end
  end

  // Coordinates always pass through; only the plot strobe is gated when clipping is built in.
  always_comb begin
    in_bounds = (vga_x < X_LIM) && (vga_y < Y_LIM);
    vga_plot  = mux_plot & (in_bounds | ~CLIP_ON);
  end

endmodule

// File: rtl/draw_sequencer.sv
// draw_sequencer: sequences the clear engine then the shape engine on a
// top-level start, handles each engine's start/done handshake and muxes the
// active engine's pixel onto the VGA adapter with the right colour.
// Optional build macro DRAW_SEQ_CLIP_EN clips plots outside the screen.
module draw_sequencer
  import lab_pkg::*;
#(
  parameter logic [2:0] CLR_COLOUR = BLACK,
  parameter int         SCREEN_W   = lab_pkg::SCREEN_W,
  parameter int         SCREEN_H   = lab_pkg::SCREEN_H
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] shp_colour,
  output logic       done,
  output logic       clr_start,
  input  logic       clr_done,
  input  logic [7:0] clr_x,
  input  logic [6:0] clr_y,
  input  logic       clr_plot,
  output logic       shp_start,
  input  logic       shp_done,
  input  logic [7:0] shp_x,
  input  logic [6:0] shp_y,
  input  logic       shp_plot,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_plot
);

  draw_seq_state state;
  draw_seq_state state_next;

  // State register with synchronous active-low reset back to idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and Moore handshake outputs; each REL state waits for the engine to drop done.
  always_comb begin
    state_next = state;
    clr_start  = 1'b0;
    shp_start  = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_CLR_RUN;
      end
      S_CLR_RUN: begin
        clr_start = 1'b1;
        if (clr_done) state_next = S_CLR_REL;
      end
      S_CLR_REL: begin
        if (!clr_done) state_next = S_SHP_RUN;
      end
      S_SHP_RUN: begin
        shp_start = 1'b1;
        if (shp_done) state_next = S_SHP_REL;
      end
      S_SHP_REL: begin
        if (!shp_done) state_next = S_DONE;
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  logic sel_clr;
  logic sel_shp;

  // Engine pixels are only routed while that engine is running, never during release.
  always_comb begin
    sel_clr = (state == S_CLR_RUN);
    sel_shp = (state == S_SHP_RUN);
  end

  pixel_mux #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_pixel_mux (
    .sel_clr    (sel_clr),
    .sel_shp    (sel_shp),
    .clr_colour (CLR_COLOUR),
    .clr_x      (clr_x),
    .clr_y      (clr_y),
    .clr_plot   (clr_plot),
    .shp_colour (shp_colour),
    .shp_x      (shp_x),
    .shp_y      (shp_y),
    .shp_plot   (shp_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

endmodule

// File: tb/tb_draw_sequencer.sv
// Scoreboard testbench for draw_sequencer: directed steps push expected
// outputs into a queue, a negedge monitor pops and compares them.
// Expectations follow DRAW_SEQ_CLIP_EN when the bench is built with it.
module tb_draw_sequencer;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [2:0] shp_colour;
  logic       done;
  logic       clr_start;
  logic       clr_done;
  logic [7:0] clr_x;
  logic [6:0] clr_y;
  logic       clr_plot;
  logic       shp_start;
  logic       shp_done;
  logic [7:0] shp_x;
  logic [6:0] shp_y;
  logic       shp_plot;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] vga_colour;
  logic       vga_plot;

`ifdef DRAW_SEQ_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  typedef struct packed {
    logic       done;
    logic       clr_start;
    logic       shp_start;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  draw_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .shp_colour (shp_colour),
    .done       (done),
    .clr_start  (clr_start),
    .clr_done   (clr_done),
    .clr_x      (clr_x),
    .clr_y      (clr_y),
    .clr_plot   (clr_plot),
    .shp_start  (shp_start),
    .shp_done   (shp_done),
    .shp_x      (shp_x),
    .shp_y      (shp_y),
    .shp_plot   (shp_plot),
    .vga_x      (vga_x),
    .vga_y      (vga_y),
    .vga_colour (vga_colour),
    .vga_plot   (vga_plot)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mkExp(input logic d, input logic cs, input logic ss,
                                 input logic [7:0] x, input logic [6:0] y,
                                 input logic [2:0] c, input logic p);
    exp_t e;
    e.done = d; e.clr_start = cs; e.shp_start = ss;
    e.x = x; e.y = y; e.colour = c; e.plot = p;
    return e;
  endfunction

  // Drive one cycle of inputs just after the edge and queue the response expected in that cycle.
  task automatic applyStimulus(input string nm, input logic r, input logic s,
                               input logic cd, input logic [7:0] cx, input logic [6:0] cy, input logic cp,
                               input logic sd, input logic [7:0] sx, input logic [6:0] sy, input logic sp,
                               input logic [2:0] sc, input exp_t e);
    @(posedge clk);
    #1;
    rst_n = r; start = s;
    clr_done = cd; clr_x = cx; clr_y = cy; clr_plot = cp;
    shp_done = sd; shp_x = sx; shp_y = sy; shp_plot = sp; shp_colour = sc;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic checkOutput(input string nm, input exp_t e);
    exp_t a;
    a = mkExp(done, clr_start, shp_start, vga_x, vga_y, vga_colour, vga_plot);
    tests_run++;
    if (a !== e) begin
      tests_failed++;
      $display("[TB] FAIL %s: got done=%b clr_start=%b shp_start=%b x=%0d y=%0d colour=%b plot=%b, want done=%b clr_start=%b shp_start=%b x=%0d y=%0d colour=%b plot=%b",
               nm, a.done, a.clr_start, a.shp_start, a.x, a.y, a.colour, a.plot,
               e.done, e.clr_start, e.shp_start, e.x, e.y, e.colour, e.plot);
    end
  endtask

  // Monitor: compare the DUT against the oldest queued expectation mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      checkOutput(name_q.pop_front(), exp_q.pop_front());
    end
  end

  initial begin
    int wait_cycles;
    rst_n = 1'b0; start = 1'b0; shp_colour = 3'd0;
    clr_done = 1'b0; clr_x = 8'd0; clr_y = 7'd0; clr_plot = 1'b0;
    shp_done = 1'b0; shp_x = 8'd0; shp_y = 7'd0; shp_plot = 1'b0;

    //                 name            rst st  cd cx      cy     cp  sd sx      sy     sp  sc        expected: done cs ss x y colour plot
    applyStimulus("reset",          0, 0, 0, 8'd0,   7'd0,  0,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(0,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("idle_plot_hid",  1, 0, 0, 8'd5,   7'd7,  1,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(0,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("idle_start",     1, 1, 0, 8'd0,   7'd0,  0,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(0,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("clr_pixel",      1, 1, 0, 8'd5,   7'd7,  1,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(0,1,0,8'd5,7'd7,3'b000,1));
    applyStimulus("clr_shp_hid",    1, 1, 0, 8'd159, 7'd119,1,  0, 8'd80,  7'd60, 1,  3'b010, mkExp(0,1,0,8'd159,7'd119,3'b000,1));
    applyStimulus("clr_done_rise",  1, 1, 1, 8'd0,   7'd0,  0,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(0,1,0,8'd0,7'd0,3'b000,0));
    applyStimulus("clr_rel_hold",   1, 1, 1, 8'd3,   7'd4,  1,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(0,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("clr_rel_drop",   1, 1, 0, 8'd3,   7'd4,  1,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(0,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("shp_pixel",      1, 1, 0, 8'd5,   7'd7,  1,  0, 8'd80,  7'd60, 1,  3'b010, mkExp(0,0,1,8'd80,7'd60,3'b010,1));
    applyStimulus("clip_x",         1, 1, 0, 8'd0,   7'd0,  0,  0, 8'd160, 7'd10, 1,  3'b010, mkExp(0,0,1,8'd160,7'd10,3'b010,!CLIP));
    applyStimulus("clip_y",         1, 1, 0, 8'd0,   7'd0,  0,  0, 8'd10,  7'd120,1,  3'b010, mkExp(0,0,1,8'd10,7'd120,3'b010,!CLIP));
    applyStimulus("clip_edge",      1, 1, 0, 8'd0,   7'd0,  0,  0, 8'd159, 7'd119,1,  3'b010, mkExp(0,0,1,8'd159,7'd119,3'b010,1));
    applyStimulus("shp_done_rise",  1, 1, 0, 8'd0,   7'd0,  0,  1, 8'd1,   7'd2,  1,  3'b101, mkExp(0,0,1,8'd1,7'd2,3'b101,1));
    applyStimulus("shp_rel",        1, 1, 0, 8'd0,   7'd0,  0,  0, 8'd1,   7'd2,  1,  3'b101, mkExp(0,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("done_high",      1, 1, 0, 8'd0,   7'd0,  0,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(1,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("done_no_rerun",  1, 0, 0, 8'd0,   7'd0,  0,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(1,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("idle_after",     1, 1, 0, 8'd0,   7'd0,  0,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(0,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("rerun_done_hi",  1, 0, 1, 8'd9,   7'd9,  1,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(0,1,0,8'd9,7'd9,3'b000,1));
    applyStimulus("rerun_clr_rel",  1, 0, 0, 8'd9,   7'd9,  1,  1, 8'd20,  7'd30, 1,  3'b111, mkExp(0,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("rerun_shp_hi",   1, 0, 0, 8'd0,   7'd0,  0,  1, 8'd20,  7'd30, 1,  3'b111, mkExp(0,0,1,8'd20,7'd30,3'b111,1));
    applyStimulus("rerun_shp_rel",  1, 0, 0, 8'd0,   7'd0,  0,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(0,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("done_no_start",  1, 1, 0, 8'd0,   7'd0,  0,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(1,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("done_start_hold",1, 1, 0, 8'd0,   7'd0,  0,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(1,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("done_drop",      1, 0, 0, 8'd0,   7'd0,  0,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(1,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("idle_restart",   1, 1, 1, 8'd0,   7'd0,  0,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(0,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("run3_clr",       1, 1, 0, 8'd0,   7'd0,  0,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(0,1,0,8'd0,7'd0,3'b000,0));
    applyStimulus("run3_still_clr", 1, 1, 1, 8'd0,   7'd0,  0,  0, 8'd0,   7'd0,  0,  3'b000, mkExp(0,1,0,8'd0,7'd0,3'b000,0));
    applyStimulus("run3_clr_rel",   1, 1, 0, 8'd0,   7'd0,  0,  0, 8'd20,  7'd30, 1,  3'b111, mkExp(0,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("run3_shp",       1, 1, 0, 8'd0,   7'd0,  0,  0, 8'd20,  7'd30, 1,  3'b111, mkExp(0,0,1,8'd20,7'd30,3'b111,1));
    applyStimulus("reset_mid",      0, 1, 0, 8'd0,   7'd0,  0,  0, 8'd20,  7'd30, 1,  3'b111, mkExp(0,0,1,8'd20,7'd30,3'b111,1));
    applyStimulus("after_reset",    1, 0, 0, 8'd0,   7'd0,  0,  0, 8'd20,  7'd30, 1,  3'b111, mkExp(0,0,0,8'd0,7'd0,3'b000,0));
    applyStimulus("idle_quiet",     1, 0, 0, 8'd0,   7'd0,  0,  0, 8'd20,  7'd30, 1,  3'b111, mkExp(0,0,0,8'd0,7'd0,3'b000,0));

    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      tests_run++;
      tests_failed++;
      $display("[TB] FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
